// File: rtl/dm_responder.sv
// Single-outstanding 64-bit memory responder with fixed request-to-response latency.
// Optional read/write statistics counters are enabled by defining DM_RESP_STATS_EN.
module dm_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wmask,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
`ifdef DM_RESP_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int unsigned IDX_W  = 13;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LANES  = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic               rd_q, err_q;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  logic [IDX_W-1:0]   req_idx;
  logic               req_in_range, req_is_rd, accept;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_rd, cur_err;
  logic               unused_addr_lsb;

  assign req_idx         = req_addr[15:3];
  assign unused_addr_lsb = ^req_addr[2:0];
  assign req_in_range    = 32'(req_idx) < DEPTH_WORDS;
  assign req_is_rd       = (req_wmask == '0);
  assign accept          = (state_q == S_IDLE) && req_valid && req_ready_q;

  // Response source: live request when responding straight from IDLE, else the latched one
  assign cur_idx = (state_q == S_IDLE) ? req_idx       : idx_q;
  assign cur_rd  = (state_q == S_IDLE) ? req_is_rd     : rd_q;
  assign cur_err = (state_q == S_IDLE) ? !req_in_range : err_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      rd_q         <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        idx_q <= req_idx;
        rd_q  <= req_is_rd;
        err_q <= !req_in_range;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Output logic; response payload is captured on entry to RESP and held there
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    if (state_d == S_RESP) begin
      if (state_q == S_RESP) begin
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
      end else begin
        resp_err_d = cur_err;
        if (cur_rd && !cur_err) resp_rdata_d = mem[cur_idx[AW-1:0]];
      end
    end
  end

  // Storage is not reset; byte lanes commit on the accepting edge
  always_ff @(posedge clk) begin
    if (accept && !req_is_rd && req_in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_wmask[i]) mem[req_idx[AW-1:0]][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef DM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Saturating counts of accepted in-range reads and writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept && req_in_range) begin
      if (req_is_rd && (rd_cnt_q != '1))  rd_cnt_q <= rd_cnt_q + 32'd1;
      if (!req_is_rd && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (LATENCY=2, DEPTH_WORDS=16).
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
`ifdef DM_RESP_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dm_responder #(.LATENCY(2), .DEPTH_WORDS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef DM_RESP_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response; holds resp_ready low for 'hold' cycles in RESP
  task automatic xact(input logic [15:0] a, input logic [7:0] m, input logic [63:0] d,
                      input int hold, output logic [63:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wmask = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    chk("resp_req_ready", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", 64'(resp_valid), 64'd0);
    chk("post_req_ready", 64'(req_ready), 64'd1);
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wmask  = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);

    rst = 1'b1;
    #1 chk("init_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Full write then read back
    xact(16'h0010, 8'hFF, 64'h1122334455667788, 0, rd, er, lat);
    chk("wr_lat", 64'(lat), 64'd2);
    chk("wr_err", 64'(er), 64'd0);
    chk("wr_rdata", rd, 64'd0);
    xact(16'h0010, 8'h00, 64'h0, 0, rd, er, lat);
    chk("rd_lat", 64'(lat), 64'd2);
    chk("rd_err", 64'(er), 64'd0);
    chk("rd_rdata", rd, 64'h1122334455667788);

    // Partial write on low four lanes
    xact(16'h0010, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0, rd, er, lat);
    xact(16'h0010, 8'h00, 64'h0, 0, rd, er, lat);
    chk("partial_rdata", rd, 64'h11223344BBBBBBBB);

    // Backpressured read, offset bits ignored
    xact(16'h0017, 8'h00, 64'h0, 5, rd, er, lat);
    chk("bp_rdata", rd, 64'h11223344BBBBBBBB);
    chk("bp_lat", 64'(lat), 64'd2);

    // Last in-range word and out-of-range accesses
    xact(16'h0000, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, rd, er, lat);
    xact(16'h0078, 8'hA5, 64'h0102030405060708, 0, rd, er, lat);
    chk("last_wr_err", 64'(er), 64'd0);
    xact(16'h007F, 8'h00, 64'h0, 0, rd, er, lat);
    chk("last_rdata_lanes", rd & 64'hFF00FF0000FF00FF, 64'h0100030000060008);
    xact(16'h0100, 8'hFF, 64'h5555555555555555, 0, rd, er, lat);
    chk("oob_wr_err", 64'(er), 64'd1);
    chk("oob_wr_rdata", rd, 64'd0);
    xact(16'h0080, 8'h00, 64'h0, 0, rd, er, lat);
    chk("oob_rd_err", 64'(er), 64'd1);
    chk("oob_rd_rdata", rd, 64'd0);
    xact(16'h0000, 8'h00, 64'h0, 0, rd, er, lat);
    chk("word0_unchanged", rd, 64'hDEADBEEFCAFEF00D);
    chk("word0_err", 64'(er), 64'd0);

    // Reset while a write waits: response dropped, write kept
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    req_wmask = 8'hFF;
    req_wdata = 64'h0F0E0D0C0B0A0908;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wmask = '0;
    @(negedge clk);
    chk("wait_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstw_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstw_req_ready", 64'(req_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rstw_hold_valid", 64'(resp_valid), 64'd0);
    end
    rst = 1'b1;
    #1 chk("rstw_init_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("rstw_idle_ready", 64'(req_ready), 64'd1);
    chk("rstw_idle_valid", 64'(resp_valid), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rstw_no_valid", 64'(resp_valid), 64'd0);
    end
    xact(16'h0020, 8'h00, 64'h0, 0, rd, er, lat);
    chk("rstw_committed", rd, 64'h0F0E0D0C0B0A0908);

    // Two more reads, two writes, one uncounted out-of-range read
    xact(16'h0010, 8'h00, 64'h0, 0, rd, er, lat);
    xact(16'h0008, 8'h01, 64'h00000000000000EE, 0, rd, er, lat);
    xact(16'h0200, 8'h00, 64'h0, 0, rd, er, lat);
    chk("oob_rd2_err", 64'(er), 64'd1);
    xact(16'h0008, 8'h80, 64'h9900000000000000, 0, rd, er, lat);
    xact(16'h000C, 8'h00, 64'h0, 0, rd, er, lat);
    chk("merged_lanes", rd & 64'hFF000000000000FF, 64'h99000000000000EE);
`ifdef DM_RESP_STATS_EN
    chk("rd_count", 64'(rd_count), 64'd3);
    chk("wr_count", 64'(wr_count), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
